softmax_wb_ctrl: RTL and testbench
==================================

SOFTMAX_WB_CTRL -- requirements
Module: softmax_wb_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 1024: words per softmax frame; range 1..2^AW.
REQ-002 SHALL have parameter AW, default 10: output memory address width.
REQ-003 SHALL have parameter DW, default 32: data word width.
REQ-004 SHALL have port clk  input  1: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port wb_ena  input  1: write-back stage enable from the softmax controller.
REQ-007 SHALL have port wb_stall  input  1: write-back stall from the softmax controller; blocks acceptance while high.
REQ-008 SHALL have port data_in  input  DW: probability word from the divider stage, valid when a word is accepted.
REQ-009 SHALL have port wr_ena  output  1: output memory write strobe.
REQ-010 SHALL have port wr_addr  output  AW: output memory write address.
REQ-011 SHALL have port wr_data  output  DW: output memory write data.
REQ-012 SHALL have port process_done  output  1: one-cycle pulse marking the final write of a frame.
REQ-013 SHALL have port busy  output  1: high while a frame is partially written (state WRITE).
REQ-014 SHALL have port err_overrun  output  1: sticky flag for a word offered after frame completion.

Function
REQ-015 SHALL define accept = wb_ena AND NOT wb_stall, evaluated each cycle.
REQ-016 SHALL implement states IDLE, WRITE, DONE, plus an AW-bit word counter cnt.
REQ-017 In IDLE, accept SHALL write word cnt=0 and move to WRITE; if DATA_SIZE=1 it SHALL move directly to DONE.
REQ-018 In WRITE, accept SHALL write word cnt and increment cnt; the accept of word DATA_SIZE-1 SHALL move to DONE.
REQ-019 Every output (wr_ena, wr_addr, wr_data, process_done) SHALL be registered; latency from the accept cycle to wr_ena=1 with wr_addr=cnt and wr_data=data_in SHALL be exactly 1 cycle.
REQ-020 wr_ena SHALL be 0 in any cycle after a non-accept cycle; wr_addr and wr_data SHALL hold their last values when wr_ena=0.
REQ-021 With wb_stall=1 or wb_ena=0 in WRITE, cnt and state SHALL hold; the frame SHALL NOT abort, and writing SHALL resume at the held cnt on the next accept.
REQ-022 process_done SHALL be 1 in exactly the cycle in which wr_ena=1 and wr_addr=DATA_SIZE-1, and 0 otherwise.
REQ-023 In DONE, cnt SHALL be 0; no write SHALL occur; the state SHALL return to IDLE on the first cycle with wb_ena=0.
REQ-024 An accept while in DONE SHALL NOT write, and SHALL set err_overrun=1 on the next edge; err_overrun SHALL stay 1 until rst.
REQ-025 busy SHALL be 1 iff the state is WRITE; busy is registered state decode.
REQ-026 cnt SHALL never exceed DATA_SIZE-1; no wrap to 0 occurs within WRITE.
REQ-027 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-028 While rst=1, the block SHALL force: state IDLE, cnt 0, wr_ena 0, wr_addr 0, wr_data 0, process_done 0, busy 0, err_overrun 0.
REQ-029 rst asserted mid-frame SHALL discard the partial frame; the first accept after release SHALL write address 0.
REQ-030 The block SHALL ignore inputs in the cycle rst deasserts only if the release misses setup; otherwise it SHALL operate normally from the first edge after release.

Verification
REQ-031 Scenario: DATA_SIZE=4, wb_ena=1, wb_stall=0 for 4 cycles, data 0xA0..0xA3 -> the bench SHALL see writes at addr 0..3 with data 0xA0..0xA3 one cycle later each, process_done=1 only with addr 3, then busy=0.
REQ-032 Scenario: DATA_SIZE=4, wb_stall=1 for 3 cycles after word 1 -> no wr_ena in the stalled window; words 2,3 SHALL be written at addr 2,3; exactly one process_done pulse.
REQ-033 Scenario: wb_ena dropped for 5 cycles mid-frame (after word 2 of 8) -> busy SHALL stay 1 and writing SHALL resume at addr 2.
REQ-034 Scenario: wb_ena held 1 for 2 extra cycles after the last word -> no extra writes and err_overrun=1; after wb_ena=0 the next frame SHALL start at addr 0 while err_overrun stays 1.
REQ-035 Scenario: rst pulsed after word 5 of 8 -> all outputs SHALL be 0 immediately (asynchronous); a new frame SHALL write addr 0..7 and pulse process_done once.
REQ-036 Scenario: DATA_SIZE=1, single accept of 0x3F -> wr_ena=1, addr 0, data 0x3F and process_done=1 in the same cycle; state DONE.

Source files
------------

// File: rtl/softmax_wb_ctrl_if.sv
// Write-back bus between the softmax controller/divider and the output-memory writer.
// The master drives the handshake and data; the slave owns the memory port and status.
interface softmax_wb_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          wb_ena;
    logic          wb_stall;
    logic [DW-1:0] data_in;
    logic          wr_ena;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          process_done;
    logic          busy;
    logic          err_overrun;

    modport master (
        output wb_ena, wb_stall, data_in,
        input  wr_ena, wr_addr, wr_data, process_done, busy, err_overrun
    );

    modport slave (
        input  wb_ena, wb_stall, data_in,
        output wr_ena, wr_addr, wr_data, process_done, busy, err_overrun
    );
endinterface

// File: rtl/softmax_wb_ctrl.sv
// Softmax write-back controller: writes one frame of DATA_SIZE probability words to
// output memory at consecutive addresses, with fully registered outputs.
module softmax_wb_ctrl #(
    parameter int DATA_SIZE = 1024,
    parameter int AW        = 10,
    parameter int DW        = 32
) (
    input  logic              clk,
    input  logic              rst,
    softmax_wb_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(DATA_SIZE - 1);

    state_t        state;
    logic [AW-1:0] cnt;
    logic          accept;

    always_comb begin
        accept = bus.wb_ena & ~bus.wb_stall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.wr_ena       <= 1'b0;
            bus.wr_addr      <= '0;
            bus.wr_data      <= '0;
            bus.process_done <= 1'b0;
            bus.busy         <= 1'b0;
            bus.err_overrun  <= 1'b0;
        end else begin
            bus.wr_ena       <= 1'b0;
            bus.process_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.wr_ena  <= 1'b1;
                        bus.wr_addr <= '0;
                        bus.wr_data <= bus.data_in;
                        if (DATA_SIZE == 1) begin
                            state            <= DONE;
                            cnt              <= '0;
                            bus.process_done <= 1'b1;
                            bus.busy         <= 1'b0;
                        end else begin
                            state    <= WRITE;
                            cnt      <= AW'(1);
                            bus.busy <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // A stall or dropped enable simply holds cnt; the frame never aborts.
                    if (accept) begin
                        bus.wr_ena  <= 1'b1;
                        bus.wr_addr <= cnt;
                        bus.wr_data <= bus.data_in;
                        if (cnt == LAST) begin
                            state            <= DONE;
                            cnt              <= '0;
                            bus.process_done <= 1'b1;
                            bus.busy         <= 1'b0;
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                end
                DONE: begin
                    if (!bus.wb_ena) begin
                        state <= IDLE;
                    end else if (accept) begin
                        bus.err_overrun <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_softmax_wb_ctrl.sv
// Directed bench for softmax_wb_ctrl: three instances (frames of 4, 8 and 1 words)
// checked cycle by cycle against a queue of expected memory writes.
module tb_softmax_wb_ctrl;
    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
        logic        done;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    wr_t         sbq[$];
    logic [9:0]  last_a[3];
    logic [31:0] last_d[3];
    logic        exp_ovr[3];

    always #5 clk = ~clk;

    softmax_wb_ctrl_if #(.AW(10), .DW(32)) if4 ();
    softmax_wb_ctrl_if #(.AW(10), .DW(32)) if8 ();
    softmax_wb_ctrl_if #(.AW(10), .DW(32)) if1 ();

    softmax_wb_ctrl #(.DATA_SIZE(4), .AW(10), .DW(32)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    softmax_wb_ctrl #(.DATA_SIZE(8), .AW(10), .DW(32)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    softmax_wb_ctrl #(.DATA_SIZE(1), .AW(10), .DW(32)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic ena, input logic stall, input logic [31:0] d);
        case (sel)
            0: begin if4.wb_ena = ena; if4.wb_stall = stall; if4.data_in = d; end
            1: begin if8.wb_ena = ena; if8.wb_stall = stall; if8.data_in = d; end
            default: begin if1.wb_ena = ena; if1.wb_stall = stall; if1.data_in = d; end
        endcase
    endtask

    task automatic get_out(input int sel, output logic we, output logic [9:0] a,
                           output logic [31:0] d, output logic pd, output logic bz,
                           output logic ov);
        case (sel)
            0: begin we = if4.wr_ena; a = if4.wr_addr; d = if4.wr_data;
                     pd = if4.process_done; bz = if4.busy; ov = if4.err_overrun; end
            1: begin we = if8.wr_ena; a = if8.wr_addr; d = if8.wr_data;
                     pd = if8.process_done; bz = if8.busy; ov = if8.err_overrun; end
            default: begin we = if1.wr_ena; a = if1.wr_addr; d = if1.wr_data;
                     pd = if1.process_done; bz = if1.busy; ov = if1.err_overrun; end
        endcase
    endtask

    task automatic check_zero(input int sel, input string tag);
        logic we, pd, bz, ov;
        logic [9:0]  a;
        logic [31:0] d;
        get_out(sel, we, a, d, pd, bz, ov);
        chk({tag, "_wr_ena"}, 64'(we), 64'd0);
        chk({tag, "_wr_addr"}, 64'(a), 64'd0);
        chk({tag, "_wr_data"}, 64'(d), 64'd0);
        chk({tag, "_done"}, 64'(pd), 64'd0);
        chk({tag, "_busy"}, 64'(bz), 64'd0);
        chk({tag, "_ovr"}, 64'(ov), 64'd0);
    endtask

    // Advance one clock and compare the selected instance against the scoreboard.
    task automatic tick(input int sel, input logic exp_busy);
        wr_t e;
        logic we, pd, bz, ov;
        logic [9:0]  a;
        logic [31:0] d;
        @(posedge clk);
        #1;
        get_out(sel, we, a, d, pd, bz, ov);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("wr_ena", 64'(we), 64'd1);
            chk("wr_addr", 64'(a), 64'(e.a));
            chk("wr_data", 64'(d), 64'(e.d));
            chk("process_done", 64'(pd), 64'(e.done));
            last_a[sel] = e.a;
            last_d[sel] = e.d;
        end else begin
            chk("idle_wr_ena", 64'(we), 64'd0);
            chk("hold_addr", 64'(a), 64'(last_a[sel]));
            chk("hold_data", 64'(d), 64'(last_d[sel]));
            chk("idle_done", 64'(pd), 64'd0);
        end
        chk("busy", 64'(bz), 64'(exp_busy));
        chk("err_overrun", 64'(ov), 64'(exp_ovr[sel]));
    endtask

    task automatic word(input int sel, input logic [31:0] d, input logic [9:0] addr,
                        input logic done, input logic exp_busy);
        drive(sel, 1'b1, 1'b0, d);
        sbq.push_back('{a: addr, d: d, done: done});
        tick(sel, exp_busy);
    endtask

    task automatic idle(input int sel, input int n, input logic exp_busy);
        drive(sel, 1'b0, 1'b0, 32'hDEAD_BEEF);
        for (int i = 0; i < n; i++) tick(sel, exp_busy);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            last_a[s] = '0; last_d[s] = '0; exp_ovr[s] = 1'b0;
            drive(s, 1'b0, 1'b0, 32'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) check_zero(s, "reset");
        rst = 1'b0;

        // Frame of 4 straight through
        for (int i = 0; i < 4; i++)
            word(0, 32'hA0 + 32'(i), 10'(i), i == 3, i != 3);
        idle(0, 1, 1'b0);

        // Stall after word 1
        word(0, 32'hB0, 10'd0, 1'b0, 1'b1);
        word(0, 32'hB1, 10'd1, 1'b0, 1'b1);
        drive(0, 1'b1, 1'b1, 32'hBAD0);
        for (int i = 0; i < 3; i++) tick(0, 1'b1);
        word(0, 32'hB2, 10'd2, 1'b0, 1'b1);
        word(0, 32'hB3, 10'd3, 1'b1, 1'b0);
        idle(0, 1, 1'b0);

        // Enable dropped for 5 cycles mid-frame of 8
        word(1, 32'hE0, 10'd0, 1'b0, 1'b1);
        word(1, 32'hE1, 10'd1, 1'b0, 1'b1);
        idle(1, 5, 1'b1);
        for (int i = 2; i < 8; i++)
            word(1, 32'hE0 + 32'(i), 10'(i), i == 7, i != 7);
        idle(1, 1, 1'b0);

        // Overrun: enable held two extra cycles after the last word
        for (int i = 0; i < 4; i++)
            word(0, 32'hC0 + 32'(i), 10'(i), i == 3, i != 3);
        drive(0, 1'b1, 1'b0, 32'hCC);
        exp_ovr[0] = 1'b1;
        tick(0, 1'b0);
        tick(0, 1'b0);
        idle(0, 1, 1'b0);
        for (int i = 0; i < 4; i++)
            word(0, 32'hD0 + 32'(i), 10'(i), i == 3, i != 3);
        idle(0, 1, 1'b0);

        // Asynchronous reset after word 5 of 8
        for (int i = 0; i < 5; i++)
            word(1, 32'hF0 + 32'(i), 10'(i), 1'b0, 1'b1);
        drive(1, 1'b0, 1'b0, 32'h0);
        #3 rst = 1'b1;
        #1;
        check_zero(1, "async_rst");
        check_zero(0, "async_rst4");
        for (int s = 0; s < 3; s++) begin
            last_a[s] = '0; last_d[s] = '0; exp_ovr[s] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++)
            word(1, 32'h100 + 32'(i), 10'(i), i == 7, i != 7);
        idle(1, 1, 1'b0);

        // Single-word frame, then an extra accept proves the DONE state
        word(2, 32'h3F, 10'd0, 1'b1, 1'b0);
        drive(2, 1'b1, 1'b0, 32'h40);
        exp_ovr[2] = 1'b1;
        tick(2, 1'b0);
        idle(2, 1, 1'b0);

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
